// File: rtl/shf_pipe_shifter_if.sv
// rtl/shf_pipe_shifter_if.sv - request/response handshake bundle for the pipelined shifter
interface shf_pipe_shifter_if #(
  parameter int SIZE_DATA = 24
);
  localparam int SIZE_SHIFT = $clog2(SIZE_DATA) + 1;

  logic                  i_valid;
  logic                  o_ready;
  logic [1:0]            i_mode;
  logic [SIZE_SHIFT-1:0] i_shift_number;
  logic [SIZE_DATA-1:0]  i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [SIZE_DATA-1:0]  o_data;
  logic                  o_sticky;

  modport slave (
    input  i_valid, i_mode, i_shift_number, i_data, i_ready,
    output o_ready, o_valid, o_data, o_sticky
  );

  modport master (
    output i_valid, i_mode, i_shift_number, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_sticky
  );
endinterface

// File: rtl/shf_pipe_shifter.sv
// rtl/shf_pipe_shifter.sv - pipelined log-shifter (lsl/lsr/asr/ror) with right-shift sticky bit
module shf_pipe_shifter #(
  parameter int SIZE_DATA  = 24,
  parameter int NUM_STAGES = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  shf_pipe_shifter_if.slave bus
);
  localparam int SIZE_SHIFT = $clog2(SIZE_DATA) + 1;
  localparam int NUM_LVL    = SIZE_SHIFT - 1;
  localparam int BASE       = NUM_LVL / NUM_STAGES;
  localparam int REM        = NUM_LVL % NUM_STAGES;
  localparam logic [SIZE_SHIFT-1:0] DATA_W = SIZE_SHIFT'(SIZE_DATA);
  localparam logic [SIZE_DATA-1:0]  ONES   = '1;

  logic adv;
  assign adv         = bus.i_ready || !bus.o_valid;
  assign bus.o_ready = adv;

  // Saturating shifts are resolved up front so the mux levels only see amounts < SIZE_DATA.
  logic [SIZE_SHIFT-1:0] eff_amt;
  logic                  sat;
  logic [SIZE_DATA-1:0]  pre_data;
  logic                  pre_sticky;
  logic [NUM_LVL-1:0]    pre_amt;

  always_comb begin
    eff_amt    = (bus.i_mode == 2'b11) ? (bus.i_shift_number % DATA_W) : bus.i_shift_number;
    sat        = (eff_amt >= DATA_W);
    pre_data   = bus.i_data;
    pre_sticky = 1'b0;
    pre_amt    = eff_amt[NUM_LVL-1:0];
    if (sat) begin
      pre_amt    = '0;
      pre_data   = (bus.i_mode == 2'b10 && bus.i_data[SIZE_DATA-1]) ? ONES : '0;
      pre_sticky = (bus.i_mode == 2'b01 || bus.i_mode == 2'b10) && (|bus.i_data);
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int LO = s * BASE + ((s < REM) ? s : REM);
    localparam int HI = LO + BASE + ((s < REM) ? 1 : 0);

    logic                 in_valid;
    logic [SIZE_DATA-1:0] in_data;
    logic                 in_sticky;
    logic [1:0]           in_mode;
    logic [NUM_LVL-1:LO]  in_amt;

    logic                 valid_q;
    logic [SIZE_DATA-1:0] data_q;
    logic [SIZE_DATA-1:0] data_d;
    logic                 sticky_q;
    logic                 sticky_d;

    if (s == 0) begin : g_src
      assign in_valid  = bus.i_valid;
      assign in_data   = pre_data;
      assign in_sticky = pre_sticky;
      assign in_mode   = bus.i_mode;
      assign in_amt    = pre_amt;
    end else begin : g_src
      assign in_valid  = g_stage[s-1].valid_q;
      assign in_data   = g_stage[s-1].data_q;
      assign in_sticky = g_stage[s-1].sticky_q;
      assign in_mode   = g_stage[s-1].g_fwd.mode_q;
      assign in_amt    = g_stage[s-1].g_fwd.amt_q;
    end

    // Level k shifts by 2**k; arithmetic fill is the current MSB, which stays the sign.
    always_comb begin
      data_d   = in_data;
      sticky_d = in_sticky;
      for (int k = LO; k < HI; k++) begin
        if (in_amt[k]) begin
          case (in_mode)
            2'b00: data_d = data_d << (1 << k);
            2'b11: data_d = (data_d >> (1 << k)) | (data_d << (SIZE_DATA - (1 << k)));
            default: begin
              sticky_d = sticky_d | (|(data_d & ~(ONES << (1 << k))));
              data_d   = (data_d >> (1 << k)) |
                         ((in_mode[1] && data_d[SIZE_DATA-1]) ? ~(ONES >> (1 << k)) : '0);
            end
          endcase
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        valid_q  <= 1'b0;
        data_q   <= '0;
        sticky_q <= 1'b0;
      end else if (adv) begin
        valid_q  <= in_valid;
        data_q   <= data_d;
        sticky_q <= sticky_d;
      end
    end

    if (s < NUM_STAGES - 1) begin : g_fwd
      logic [1:0]          mode_q;
      logic [NUM_LVL-1:HI] amt_q;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          mode_q <= 2'b00;
          amt_q  <= '0;
        end else if (adv) begin
          mode_q <= in_mode;
          amt_q  <= in_amt[NUM_LVL-1:HI];
        end
      end
    end
  end

  assign bus.o_valid  = g_stage[NUM_STAGES-1].valid_q;
  assign bus.o_data   = g_stage[NUM_STAGES-1].data_q;
  assign bus.o_sticky = g_stage[NUM_STAGES-1].sticky_q;
endmodule
